// File: rtl/sibling_path_streamer_pkg.sv
// ---------------------------------------------------------------------------
// sibling_path_streamer_pkg
// Shared definitions for the sibling-path streamer:
//   - D_HYPERCUBE : number of sibling seeds (one per tree level)
//   - state_t     : streamer FSM states (IDLE=0, READ=1, DRAIN=2, DONE=3)
//   - lambda_of() : security level -> LAMBDA (seed width) for "L1"/"L3"/"L5"
// ---------------------------------------------------------------------------
package sibling_path_streamer_pkg;

   localparam int D_HYPERCUBE = 8;
   localparam int WORD_W      = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Parameter set is a two-character tag packed into 16 bits.
   function automatic int lambda_of(input logic [15:0] ps);
      int lambda;
      lambda = 128;
      if (ps == "L3") lambda = 192;
      if (ps == "L5") lambda = 256;
      return lambda;
   endfunction

endpackage

// File: rtl/sibling_path_fifo2.sv
// ---------------------------------------------------------------------------
// sibling_path_fifo2
// Two-entry synchronous FIFO with a registered head (dout is the head
// register itself). Absorbs the one-cycle memory read latency.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (flushes the FIFO)
//   push, din    write strobe / data (ignored when full without a pop)
//   pop          remove head (ignored when empty)
//   dout         head entry
//   full, empty  status flags
//   count        number of stored entries (0..2)
// Simultaneous push and pop keeps the count and preserves order.
// ---------------------------------------------------------------------------
module sibling_path_fifo2 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] head_reg;
   logic [WIDTH-1:0] tail_reg;
   logic [1:0]       count_reg;
   logic             push_ok;
   logic             pop_ok;

   assign pop_ok  = pop && (count_reg != 2'd0);
   assign push_ok = push && ((count_reg != 2'd2) || pop_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= 2'd0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (count_reg == 2'd0) head_reg <= din;
               else                   tail_reg <= din;
               count_reg <= count_reg + 2'd1;
            end
            2'b01: begin
               head_reg  <= tail_reg;
               count_reg <= count_reg - 2'd1;
            end
            2'b11: begin
               // With one entry the new word becomes the head directly;
               // with two, the tail moves up and the new word queues behind.
               if (count_reg == 2'd2) begin
                  head_reg <= tail_reg;
                  tail_reg <= din;
               end else begin
                  head_reg <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign dout  = head_reg;
   assign full  = (count_reg == 2'd2);
   assign empty = (count_reg == 2'd0);
   assign count = count_reg;

endmodule

// File: rtl/sibling_path_streamer.sv
// ---------------------------------------------------------------------------
// sibling_path_streamer
// Reads the D_HYPERCUBE sibling seeds back out of the tree-seed memory
// (addr = level*WORDS_PER_SEED + word, ascending 0..N_WORDS-1) and streams
// them as 32-bit words over a valid/ready port.
// Optional feature macro: SIBLING_PATH_LAST_EN adds o_data_last, high with
// the final word of every seed.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_start            one-cycle start pulse (ignored unless idle)
//   o_busy             high while a stream is in progress (incl. done cycle)
//   o_done             one-cycle pulse after the final word is accepted
//   o_mem_addr         memory read address (holds last issued address)
//   o_mem_rd_en        memory read strobe
//   i_mem_q            read data, valid one cycle after o_mem_rd_en
//   o_data, o_data_valid, i_data_ready   output stream
//   o_data_last        seed boundary flag (SIBLING_PATH_LAST_EN only)
// ---------------------------------------------------------------------------
module sibling_path_streamer
   import sibling_path_streamer_pkg::*;
#(
   parameter  logic [15:0] PARAMETER_SET  = "L1",
   localparam int          SEED_SIZE      = lambda_of(PARAMETER_SET),
   localparam int          WORDS_PER_SEED = SEED_SIZE / WORD_W,
   localparam int          N_WORDS        = D_HYPERCUBE * WORDS_PER_SEED,
   localparam int          ADDR_W         = $clog2(N_WORDS)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_rd_en,
   input  logic [31:0]       i_mem_q,
   output logic [31:0]       o_data,
   output logic              o_data_valid,
   input  logic              i_data_ready
`ifdef SIBLING_PATH_LAST_EN
   ,
   output logic              o_data_last
`endif
);

   localparam int                CNT_W     = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  N_WORDS_C = CNT_W'(N_WORDS);
   localparam logic [CNT_W-1:0]  LAST_C    = CNT_W'(N_WORDS - 1);
`ifdef SIBLING_PATH_LAST_EN
   localparam int                FIFO_W    = 33;
   localparam int                WI_W      = $clog2(WORDS_PER_SEED);
   localparam logic [WI_W-1:0]   LAST_WI   = WI_W'(WORDS_PER_SEED - 1);
`else
   localparam int                FIFO_W    = 32;
`endif

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    rd_cnt_reg;
   logic [CNT_W-1:0]    wr_cnt_reg;
   logic                inflight_reg;
   logic [ADDR_W-1:0]   addr_hold_reg;
   logic                rd_en;
   logic                has_room;
   logic                start_ok;

   logic                fifo_push;
   logic                fifo_pop;
   logic [FIFO_W-1:0]   fifo_din;
   logic [FIFO_W-1:0]   fifo_dout;
   logic                fifo_full;
   logic                fifo_empty;
   logic [1:0]          fifo_count;

   assign start_ok = (state_reg == IDLE) && i_start;

   // A read may be issued when, after this cycle's pop, the FIFO entries
   // plus the read already in flight leave space for one more word. Taking
   // the pop into account is what sustains one word per cycle.
   assign has_room = fifo_full ? (fifo_pop && !inflight_reg)
                               : ((fifo_count == 2'd0) || fifo_pop || !inflight_reg);
   assign rd_en    = (state_reg == READ) && (rd_cnt_reg < N_WORDS_C) && has_room;

   assign fifo_push = inflight_reg;
   assign fifo_pop  = !fifo_empty && i_data_ready;

   always_comb begin
      state_next = state_reg;
      o_busy     = 1'b0;
      o_done     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (i_start) state_next = READ;
         end
         READ: begin
            o_busy = 1'b1;
            if (rd_en && (rd_cnt_reg == LAST_C)) state_next = DRAIN;
         end
         DRAIN: begin
            o_busy = 1'b1;
            // All reads are issued; the stream ends when the last word leaves.
            if (fifo_pop && (wr_cnt_reg == LAST_C)) state_next = DONE;
         end
         DONE: begin
            o_busy     = 1'b1;
            o_done     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg     <= IDLE;
         rd_cnt_reg    <= '0;
         wr_cnt_reg    <= '0;
         inflight_reg  <= 1'b0;
         addr_hold_reg <= '0;
      end else begin
         state_reg    <= state_next;
         inflight_reg <= rd_en;
         if (start_ok) begin
            rd_cnt_reg    <= '0;
            wr_cnt_reg    <= '0;
            addr_hold_reg <= '0;
         end else begin
            if (rd_en) begin
               rd_cnt_reg    <= rd_cnt_reg + 1'b1;
               addr_hold_reg <= rd_cnt_reg[ADDR_W-1:0];
            end
            if (fifo_pop) wr_cnt_reg <= wr_cnt_reg + 1'b1;
         end
      end
   end

   // Address follows the read counter while reading, then holds the last
   // issued address so a stalled stream shows where it stopped.
   assign o_mem_addr  = rd_en ? rd_cnt_reg[ADDR_W-1:0] : addr_hold_reg;
   assign o_mem_rd_en = rd_en;

`ifdef SIBLING_PATH_LAST_EN
   logic [WI_W-1:0] word_idx_reg;
   logic            last_pipe_reg;

   // Seed-boundary flag travels alongside the read so it lands in the FIFO
   // in the same cycle as its data word.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         word_idx_reg  <= '0;
         last_pipe_reg <= 1'b0;
      end else begin
         last_pipe_reg <= rd_en && (word_idx_reg == LAST_WI);
         if (start_ok) begin
            word_idx_reg <= '0;
         end else if (rd_en) begin
            word_idx_reg <= (word_idx_reg == LAST_WI) ? '0 : word_idx_reg + 1'b1;
         end
      end
   end

   assign fifo_din    = {last_pipe_reg, i_mem_q};
   assign o_data_last = fifo_dout[32] && !fifo_empty;
`else
   assign fifo_din    = i_mem_q;
`endif

   sibling_path_fifo2 #(
      .WIDTH (FIFO_W)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign o_data       = fifo_dout[31:0];
   assign o_data_valid = !fifo_empty;

endmodule

// File: tb/tb_sibling_path_streamer.sv
// ---------------------------------------------------------------------------
// tb_sibling_path_streamer
// Directed bench for sibling_path_streamer. Default build runs parameter set
// L1; with SIBLING_PATH_LAST_EN defined it runs L5 and checks o_data_last.
// A negedge monitor compares every cycle against the expected stream
// (memory word k = 32'hA000_0000 + k, delivered in ascending order).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sibling_path_streamer;

`ifdef SIBLING_PATH_LAST_EN
   localparam logic [15:0] PSET = "L5";
`else
   localparam logic [15:0] PSET = "L1";
`endif
   localparam int LAMBDA   = (PSET == "L5") ? 256 : (PSET == "L3") ? 192 : 128;
   localparam int WPS      = LAMBDA / 32;
   localparam int D_HC     = 8;
   localparam int N        = D_HC * WPS;
   localparam int AW       = $clog2(N);
   // Hand-computed timing/data pins: L1 -> done at 35, last word 0xA000001F;
   // L5 -> done at 67, last word 0xA000003F.
   localparam int          EXP_DONE      = (PSET == "L5") ? 67 : 35;
   localparam logic [31:0] EXP_LAST_WORD = (PSET == "L5") ? 32'hA000_003F : 32'hA000_001F;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_start;
   logic          o_busy;
   logic          o_done;
   logic [AW-1:0] o_mem_addr;
   logic          o_mem_rd_en;
   logic [31:0]   i_mem_q = '0;
   logic [31:0]   o_data;
   logic          o_data_valid;
   logic          i_data_ready;
`ifdef SIBLING_PATH_LAST_EN
   logic          o_data_last;
`endif

   sibling_path_streamer #(
      .PARAMETER_SET (PSET)
   ) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_start      (i_start),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_mem_addr   (o_mem_addr),
      .o_mem_rd_en  (o_mem_rd_en),
      .i_mem_q      (i_mem_q),
      .o_data       (o_data),
      .o_data_valid (o_data_valid),
      .i_data_ready (i_data_ready)
`ifdef SIBLING_PATH_LAST_EN
      ,
      .o_data_last  (o_data_last)
`endif
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Tree-seed memory with one-cycle registered read.
   logic [31:0] mem [0:N-1];
   initial for (int k = 0; k < N; k++) mem[k] = 32'hA000_0000 + k;
   always @(posedge i_clk) if (o_mem_rd_en) i_mem_q <= mem[o_mem_addr];

   int checks = 0;
   int passes = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Model / monitor state
   bit          mon_en = 0;
   int          start_cyc = 0;
   int          acc_cnt, rd_cnt_m, done_cnt, done_rel, first_rd_rel, first_valid_rel, last_rel;
   int          max_addr, last_cnt;
   bit          prev_stall;
   logic [31:0] prev_data, first_word, last_word;

   task automatic model_clear();
      acc_cnt = 0; rd_cnt_m = 0; done_cnt = 0; done_rel = -1;
      first_rd_rel = -1; first_valid_rel = -1; last_rel = -1;
      max_addr = -1; last_cnt = 0; prev_stall = 0;
      prev_data = '0; first_word = '0; last_word = '0;
   endtask

   always @(negedge i_clk) begin
      int rel;
      rel = cyc - start_cyc;
      if (i_rst_n && mon_en) begin
         check("busy", o_busy, (rel >= 1) && (done_cnt == 0));
         if (o_mem_rd_en) begin
            check("rd_addr", o_mem_addr, rd_cnt_m);
            if (first_rd_rel < 0) first_rd_rel = rel;
            if (int'(o_mem_addr) > max_addr) max_addr = int'(o_mem_addr);
            rd_cnt_m++;
         end
         if (o_data_valid) begin
            if (first_valid_rel < 0) first_valid_rel = rel;
            if (prev_stall) check("hold_data", o_data, prev_data);
         end else if (prev_stall) begin
            check("hold_valid", o_data_valid, 1'b1);
         end
         if (o_data_valid && i_data_ready) begin
            check("word", o_data, 32'hA000_0000 + acc_cnt);
`ifdef SIBLING_PATH_LAST_EN
            check("last_flag", o_data_last, (acc_cnt % WPS) == WPS - 1);
            if (o_data_last) last_cnt++;
`endif
            if (acc_cnt == 0) first_word = o_data;
            acc_cnt++;
            if (acc_cnt == N) begin last_rel = rel; last_word = o_data; end
         end
         check("outstanding_le2", (rd_cnt_m - acc_cnt) <= 2, 1'b1);
         prev_stall = o_data_valid && !i_data_ready;
         prev_data  = o_data;
         if (o_done) begin
            check("done_after_all_words", acc_cnt, N);
            done_cnt++;
            done_rel = rel;
         end
      end
   end

   // Ready pattern per scenario: 0 always high, 1 random with a 5-cycle gap,
   // 2 low for 20 cycles after start, 3/4/5 always high.
   function automatic logic ready_for(input int mode, input int r);
      logic rdy;
      rdy = 1'b1;
      if (mode == 1) rdy = (r >= 14 && r < 19) ? 1'b0 : ($urandom_range(0, 9) < 6);
      if (mode == 2) rdy = (r >= 20);
      return rdy;
   endfunction

   task automatic run_stream(input int mode, input int budget);
      model_clear();
      @(posedge i_clk); #1;
      start_cyc    = cyc;
      i_start      = 1'b1;
      i_data_ready = ready_for(mode, 0);
      mon_en       = 1;
      for (int r = 1; r < budget; r++) begin
         @(posedge i_clk); #1;
         i_start      = (mode == 3 && r == 10) || (mode == 4 && r == N + 3);
         i_data_ready = ready_for(mode, r);
         if (mode == 2 && r == 20) begin
            check("stall_max_addr", max_addr, 1);
            check("stall_reads", rd_cnt_m, 2);
            check("stall_addr_out", o_mem_addr, 1);
         end
         if (mode == 5 && acc_cnt == 12) begin
            i_rst_n = 1'b0;
            mon_en  = 0;
            #1;
            check("rst_busy", o_busy, 0);
            check("rst_done", o_done, 0);
            check("rst_rd_en", o_mem_rd_en, 0);
            check("rst_addr", o_mem_addr, 0);
            check("rst_data", o_data, 0);
            check("rst_valid", o_data_valid, 0);
`ifdef SIBLING_PATH_LAST_EN
            check("rst_last", o_data_last, 0);
`endif
            repeat (2) @(posedge i_clk);
            #1 i_rst_n = 1'b1;
            break;
         end
         if (done_cnt > 0 && r > done_rel + 4) break;
      end
      i_start = 1'b0;
      if (mode != 5) begin
         mon_en = 0;
         check("done_count", done_cnt, 1);
         check("words_delivered", acc_cnt, N);
         check("reads_issued", rd_cnt_m, N);
`ifdef SIBLING_PATH_LAST_EN
         check("last_pulses", last_cnt, D_HC);
`endif
         $display("stream mode %0d: words=%0d reads=%0d done_at=%0d", mode, acc_cnt, rd_cnt_m, done_rel);
      end else begin
         $display("stream mode 5: reset applied after %0d words", acc_cnt);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      i_rst_n      = 1'b0;
      i_start      = 1'b0;
      i_data_ready = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      check("reset_busy", o_busy, 0);
      check("reset_done", o_done, 0);
      check("reset_rd_en", o_mem_rd_en, 0);
      check("reset_addr", o_mem_addr, 0);
      check("reset_valid", o_data_valid, 0);
      check("reset_data", o_data, 0);
      i_rst_n = 1'b1;
      repeat (2) @(posedge i_clk);

      // Ready high: pin timing and the first/last words to literal values.
      run_stream(0, 4 * N);
      check("first_rd_cycle", first_rd_rel, 1);
      check("first_valid_cycle", first_valid_rel, 3);
      check("last_word_cycle", last_rel, EXP_DONE - 1);
      check("done_cycle", done_rel, EXP_DONE);
      check("first_word", first_word, 32'hA000_0000);
      check("last_word", last_word, EXP_LAST_WORD);

      run_stream(1, 10 * N);   // random ready with a 5-cycle stall
      run_stream(2, 6 * N);    // ready low for 20 cycles after start
      run_stream(3, 4 * N);    // second start mid-stream ignored
      run_stream(0, 4 * N);    // following stream still complete
      run_stream(4, 4 * N);    // start on the done cycle ignored
      @(posedge i_clk); #1;
      check("idle_after_done_start", o_busy, 0);
      run_stream(5, 4 * N);    // asynchronous reset at word 12
      run_stream(0, 4 * N);    // restart streams from addr 0

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
